// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
// Holds the frame FSM encoding and the baud divisor helper.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } uart_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART framer.
// Head byte is visible on o_dout whenever o_empty is low.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness uses the pre-pop count, so a push while full is dropped even if a pop coincides.
    assign w_do_push = i_push && (r_count != FULL_COUNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered UART transmitter: queues strobed bytes and sends 8N1 (or 8E1/8O1) frames.
// Back-to-back frames follow each other with no idle gap while the FIFO has data.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tx_flag,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int BAUD_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

    uart_state_e                 r_state;
    uart_state_e                 w_next_state;
    logic [BAUD_W-1:0]           r_baud_cnt;
    logic [BIT_W-1:0]            r_bit_cnt;
    logic [DATA_W-1:0]           r_shift;
    logic                        r_parity;
    logic                        r_tx;
    logic                        r_busy;
    logic                        r_fifo_full;
    logic                        r_overflow;
    logic                        w_baud_end;
    logic                        w_pop;
    logic                        w_tx_next;
    logic [DATA_W-1:0]           w_fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (tx_flag),
        .i_pop   (w_pop),
        .i_din   (tx_data),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_baud_end = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The line level is registered from the current state, so tx trails the state by one cycle.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_end) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shift[r_bit_cnt];
                if (w_baud_end && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_tx_next = r_parity;
                if (w_baud_end) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_fifo_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if ((r_state == IDLE) || w_baud_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
            if (r_state != DATA) begin
                r_bit_cnt <= '0;
            end else if (w_baud_end) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_pop) begin
                r_shift  <= w_fifo_dout;
                r_parity <= (^w_fifo_dout) ^ PARITY_ODD_BIT;
            end
            r_tx        <= w_tx_next;
            r_busy      <= (r_state != IDLE) || (w_fifo_count != '0);
            r_fifo_full <= w_fifo_full;
            r_overflow  <= tx_flag && w_fifo_full;
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_full = r_fifo_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: one default-rate instance, one fast instance,
// and two fast parity instances (odd and even) sharing one stimulus port.
module tb_uart_byte_tx;

    logic       clock = 1'b0;
    logic       resetMain;
    logic       resetFast;
    logic       flagDef, flagFast, flagPar;
    logic [7:0] dataDef, dataFast, dataPar;
    logic       txDef, busyDef, fullDef, ovDef;
    logic       txFast, busyFast, fullFast, ovFast;
    logic       txOdd, busyOdd, fullOdd, ovOdd;
    logic       txEven, busyEven, fullEven, ovEven;

    int         testsRun = 0;
    int         failCount = 0;
    int         framingErrors = 0;
    logic [7:0] rxQ[$];

    typedef struct {
        int          dut;
        logic [7:0]  data;
        int          nPer;
        logic [31:0] expLine;
        int          baud;
        string       name;
    } frame_vec_t;

    frame_vec_t vecs[5];

    uart_byte_tx dutDef (
        .sys_clk(clock), .sys_rst(resetMain), .tx_flag(flagDef), .tx_data(dataDef),
        .tx(txDef), .busy(busyDef), .fifo_full(fullDef), .overflow(ovDef)
    );

    uart_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100)) dutFast (
        .sys_clk(clock), .sys_rst(resetFast), .tx_flag(flagFast), .tx_data(dataFast),
        .tx(txFast), .busy(busyFast), .fifo_full(fullFast), .overflow(ovFast)
    );

    uart_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY_EN(1), .PARITY_ODD(1)) dutOdd (
        .sys_clk(clock), .sys_rst(resetMain), .tx_flag(flagPar), .tx_data(dataPar),
        .tx(txOdd), .busy(busyOdd), .fifo_full(fullOdd), .overflow(ovOdd)
    );

    uart_byte_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY_EN(1), .PARITY_ODD(0)) dutEven (
        .sys_clk(clock), .sys_rst(resetMain), .tx_flag(flagPar), .tx_data(dataPar),
        .tx(txEven), .busy(busyEven), .fifo_full(fullEven), .overflow(ovEven)
    );

    always #5 clock = ~clock;

    // Returns {tx, busy, fifo_full, overflow} of the selected instance.
    function automatic logic [3:0] statusOf(input int d);
        case (d)
            0:       return {txDef, busyDef, fullDef, ovDef};
            1:       return {txFast, busyFast, fullFast, ovFast};
            2:       return {txOdd, busyOdd, fullOdd, ovOdd};
            default: return {txEven, busyEven, fullEven, ovEven};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] value);
        @(negedge clock);
        case (d)
            0:       begin flagDef = 1'b1;  dataDef = value;  end
            1:       begin flagFast = 1'b1; dataFast = value; end
            default: begin flagPar = 1'b1;  dataPar = value;  end
        endcase
        @(negedge clock);
        flagDef  = 1'b0;
        flagFast = 1'b0;
        flagPar  = 1'b0;
    endtask

    // Called half a cycle after tx falls; checks the line level on every cycle of every bit period.
    task automatic checkLine(input int d, input logic [31:0] expLine, input int nPer, input int baud, input string name);
        logic [3:0] st;
        int         bad;
        int         ovSeen;
        logic       lastBusy;
        ovSeen   = 0;
        lastBusy = 1'b0;
        for (int p = 0; p < nPer; p++) begin
            bad = 0;
            for (int k = 0; k < baud; k++) begin
                st = statusOf(d);
                if (st[3] !== expLine[p]) bad++;
                if (st[0] !== 1'b0) ovSeen++;
                if ((p == nPer - 1) && (k == baud - 1)) lastBusy = st[2];
                @(negedge clock);
            end
            checkOutput($sformatf("%s_period%0d_badCycles", name, p), 32'(bad), 32'd0);
        end
        checkOutput($sformatf("%s_busyLastCycle", name), 32'(lastBusy), 32'd1);
        st = statusOf(d);
        checkOutput($sformatf("%s_busyFall", name), 32'(st[2]), 32'd0);
        checkOutput($sformatf("%s_txIdle", name), 32'(st[3]), 32'd1);
        checkOutput($sformatf("%s_overflowQuiet", name), 32'(ovSeen), 32'd0);
    endtask

    // Simple receiver on the fast instance: mid-bit sampling, 10 cycles per bit.
    initial begin
        logic [7:0] rxByte;
        rxByte = '0;
        forever begin
            @(negedge clock);
            if (txFast === 1'b0) begin
                repeat (5) @(negedge clock);
                for (int k = 0; k < 8; k++) begin
                    repeat (10) @(negedge clock);
                    rxByte[k] = txFast;
                end
                repeat (10) @(negedge clock);
                if (txFast === 1'b1) rxQ.push_back(rxByte);
                else framingErrors++;
            end
        end
    end

    initial begin
        logic [3:0] st;
        int         ovCount;
        int         firstOv;
        int         badTx;
        int         badBusy;

        vecs[0] = '{0, 8'h55, 10, 32'h0000_02AA, 5208, "def55"};
        vecs[1] = '{1, 8'h80, 10, 32'h0000_0300, 10,   "fast80"};
        vecs[2] = '{1, 8'hA3, 10, 32'h0000_0346, 10,   "fastA3"};
        vecs[3] = '{2, 8'h07, 11, 32'h0000_040E, 10,   "odd07"};
        vecs[4] = '{3, 8'h07, 11, 32'h0000_060E, 10,   "even07"};

        resetMain = 1'b1;
        resetFast = 1'b1;
        flagDef = 1'b0; flagFast = 1'b0; flagPar = 1'b0;
        dataDef = '0;   dataFast = '0;   dataPar = '0;
        #1;
        for (int d = 0; d < 4; d++) checkOutput($sformatf("resetState%0d", d), 32'(statusOf(d)), 32'h8);
        repeat (3) @(negedge clock);
        resetMain = 1'b0;
        resetFast = 1'b0;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 4; d++) checkOutput($sformatf("idleAfterReset%0d", d), 32'(statusOf(d)), 32'h8);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].data);
            st = statusOf(vecs[i].dut);
            checkOutput({vecs[i].name, "_busyBeforeN1"}, 32'(st[2]), 32'd0);
            @(negedge clock);
            st = statusOf(vecs[i].dut);
            checkOutput({vecs[i].name, "_txHighAtN1"}, 32'(st[3]), 32'd1);
            checkOutput({vecs[i].name, "_busyAtN1"}, 32'(st[2]), 32'd1);
            @(negedge clock);
            checkLine(vecs[i].dut, vecs[i].expLine, vecs[i].nPer, vecs[i].baud, vecs[i].name);
            repeat (3) @(negedge clock);
        end

        // Two bytes two cycles apart must produce contiguous frames.
        applyStimulus(1, 8'hA3);
        @(negedge clock);
        checkOutput("pair_txHighAtN1", 32'(txFast), 32'd1);
        flagFast = 1'b1;
        dataFast = 8'h3C;
        @(negedge clock);
        flagFast = 1'b0;
        checkLine(1, 32'h0009_E346, 20, 10, "pairA3_3C");
        repeat (5) @(negedge clock);

        // Burst of 20 consecutive strobes into a 16-deep FIFO.
        rxQ.delete();
        ovCount = 0;
        firstOv = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i == 17) checkOutput("burst_fullBefore", 32'(fullFast), 32'd0);
            if (i == 18) checkOutput("burst_fullAfter", 32'(fullFast), 32'd1);
            if (ovFast === 1'b1) begin
                ovCount++;
                if (firstOv < 0) firstOv = i;
            end
            if (i < 20) begin
                flagFast = 1'b1;
                dataFast = 8'(i);
            end else begin
                flagFast = 1'b0;
            end
        end
        checkOutput("burst_overflowCount", 32'(ovCount), 32'd3);
        checkOutput("burst_firstOverflow", 32'(firstOv), 32'd18);
        repeat (1700) @(negedge clock);
        checkOutput("burst_rxCount", 32'(rxQ.size()), 32'd17);
        for (int j = 0; j < 17; j++) begin
            checkOutput($sformatf("burst_rxByte%0d", j),
                        (j < rxQ.size()) ? 32'(rxQ[j]) : 32'hFFFF_FFFF, 32'(j));
        end
        checkOutput("burst_busyDone", 32'(busyFast), 32'd0);

        // Reset during data bit 3 of 0xFF with three bytes still queued.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            flagFast = 1'b1;
            case (i)
                0:       dataFast = 8'hFF;
                1:       dataFast = 8'h11;
                2:       dataFast = 8'h22;
                default: dataFast = 8'h33;
            endcase
        end
        @(negedge clock);
        flagFast = 1'b0;
        repeat (43) @(negedge clock);
        checkOutput("rst_busyBefore", 32'(busyFast), 32'd1);
        resetFast = 1'b1;
        #1;
        checkOutput("rst_txImmediate", 32'(txFast), 32'd1);
        checkOutput("rst_busyImmediate", 32'(busyFast), 32'd0);
        checkOutput("rst_fullImmediate", 32'(fullFast), 32'd0);
        checkOutput("rst_overflowImmediate", 32'(ovFast), 32'd0);
        repeat (3) @(negedge clock);
        resetFast = 1'b0;
        badTx = 0;
        badBusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (txFast !== 1'b1) badTx++;
            if (busyFast !== 1'b0) badBusy++;
        end
        checkOutput("rst_lineQuietAfter", 32'(badTx), 32'd0);
        checkOutput("rst_busyQuietAfter", 32'(badBusy), 32'd0);
        rxQ.delete();
        applyStimulus(1, 8'h5A);
        repeat (130) @(negedge clock);
        checkOutput("rst_newFrameCount", 32'(rxQ.size()), 32'd1);
        checkOutput("rst_newFrameByte", (rxQ.size() > 0) ? 32'(rxQ[0]) : 32'hFFFF_FFFF, 32'h5A);
        checkOutput("framingErrors", 32'(framingErrors), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
